// File: rtl/q16_pkg.sv
// ----------------------------------------------------------------------------
// q16_pkg
// Shared Q16.16 fixed-point definitions used by the vector normaliser and the
// reciprocal unit it talks to.
//   Q_FRAC / Q_ONE / Q_TWO / Q_MAX / Q_MIN : format constants
//   state_t                                : normaliser FSM encoding
//   qmult()                                : rounded Q16.16 multiply (wrapping)
//   sat_add()                              : saturating Q16.16 addition
// ----------------------------------------------------------------------------
package q16_pkg;

   localparam int          Q_FRAC = 16;
   localparam logic [31:0] Q_ONE  = 32'h0001_0000;
   localparam logic [31:0] Q_TWO  = 32'h0002_0000;
   localparam logic [31:0] Q_MAX  = 32'h7FFF_FFFF;
   localparam logic [31:0] Q_MIN  = 32'h8000_0000;

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_EMIT = 2'd3
   } state_t;

   // Rounded multiply: full signed product, add half an LSB, keep the middle
   // 32 bits. Overflow wraps; the reciprocal unit uses the identical rounding.
   function automatic logic [31:0] qmult(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      // Sign-extended operands make the low 64 bits of the unsigned product
      // equal to the signed product.
      p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      p = p + 64'h0000_0000_0000_8000;
      return p[Q_FRAC+31:Q_FRAC];
   endfunction

   // Two's-complement add clamped to the representable range.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {a[31], a} + {b[31], b};
      if (s[32] != s[31]) begin
         return s[32] ? Q_MIN : Q_MAX;
      end else begin
         return s[31:0];
      end
   endfunction

endpackage

// File: rtl/vec_normalizer.sv
// ----------------------------------------------------------------------------
// vec_normalizer
// Buffers one vector of signed Q16.16 elements, sums them, asks the external
// reciprocal unit for 1/sum and then streams every element multiplied by that
// reciprocal, so the emitted vector sums to one.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : element input handshake; in_data, in_last
//   out_valid/out_ready : normalised element handshake; out_data, out_last
//   rcp_req_valid/x     : single-cycle request to the reciprocal unit
//   rcp_rsp_valid/y     : reciprocal result
//   busy                : a vector is in flight
//   err                 : current vector aborted (sum <= 0 or no response)
// All outputs are registered.
// ----------------------------------------------------------------------------
module vec_normalizer
   import q16_pkg::*;
#(
   parameter int N       = 8,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        rcp_req_valid,
   output logic [31:0] rcp_req_x,
   input  logic        rcp_rsp_valid,
   input  logic [31:0] rcp_rsp_y,
   output logic        busy,
   output logic        err
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W = $clog2(N + 1);
   localparam int TM_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t             state_r,     state_nx;
   logic [CNT_W-1:0]   count_r,     count_nx;
   logic [31:0]        sum_r,       sum_nx;
   logic [31:0]        recip_r,     recip_nx;
   logic [IDX_W-1:0]   rd_idx_r,    rd_idx_nx;
   logic [TM_W-1:0]    timer_r,     timer_nx;
   logic [31:0]        buf_r [N];

   logic               in_ready_r,  in_ready_nx;
   logic               out_valid_r, out_valid_nx;
   logic [31:0]        out_data_r,  out_data_nx;
   logic               out_last_r,  out_last_nx;
   logic               req_valid_r, req_valid_nx;
   logic [31:0]        req_x_r,     req_x_nx;
   logic               busy_r,      busy_nx;
   logic               err_r,       err_nx;

   logic               buf_wr_s;
   logic [31:0]        sum_acc_s;
   logic [IDX_W-1:0]   rd_next_s;

   // Strictly positive in two's complement.
   function automatic logic is_pos(input logic [31:0] v);
      return (v[31] == 1'b0) && (v != 32'h0000_0000);
   endfunction

   // Next-state and next-output logic for the whole block.
   always_comb begin
      state_nx     = state_r;
      count_nx     = count_r;
      sum_nx       = sum_r;
      recip_nx     = recip_r;
      rd_idx_nx    = rd_idx_r;
      timer_nx     = timer_r;
      out_valid_nx = out_valid_r;
      out_data_nx  = out_data_r;
      out_last_nx  = out_last_r;
      req_valid_nx = 1'b0;
      req_x_nx     = req_x_r;
      err_nx       = err_r;
      buf_wr_s     = 1'b0;
      sum_acc_s    = sat_add(sum_r, in_data);
      rd_next_s    = rd_idx_r + IDX_W'(1);

      case (state_r)
         S_LOAD: begin
            if (in_valid && in_ready_r) begin
               buf_wr_s = 1'b1;
               count_nx = count_r + CNT_W'(1);
               sum_nx   = sum_acc_s;
               if (count_r == CNT_W'(0)) begin
                  err_nx = 1'b0;
               end else begin
                  err_nx = err_r;
               end
               // The N-th element closes the vector even without in_last.
               // The request is raised here so it is visible in REQ.
               if (in_last || (count_r == CNT_W'(N - 1))) begin
                  state_nx = S_REQ;
                  if (is_pos(sum_acc_s)) begin
                     req_valid_nx = 1'b1;
                     req_x_nx     = sum_acc_s;
                  end else begin
                     req_valid_nx = 1'b0;
                  end
               end else begin
                  state_nx = S_LOAD;
               end
            end else begin
               buf_wr_s = 1'b0;
            end
         end

         S_REQ: begin
            if (is_pos(sum_r)) begin
               state_nx = S_WAIT;
               timer_nx = TM_W'(0);
            end else begin
               // Nothing to normalise by: emit zeros and flag the vector.
               state_nx     = S_EMIT;
               recip_nx     = 32'h0000_0000;
               err_nx       = 1'b1;
               rd_idx_nx    = IDX_W'(0);
               out_valid_nx = 1'b1;
               out_data_nx  = qmult(buf_r[0], 32'h0000_0000);
               out_last_nx  = (count_r == CNT_W'(1));
            end
         end

         S_WAIT: begin
            timer_nx = timer_r + TM_W'(1);
            if (rcp_rsp_valid) begin
               state_nx     = S_EMIT;
               recip_nx     = rcp_rsp_y;
               rd_idx_nx    = IDX_W'(0);
               out_valid_nx = 1'b1;
               out_data_nx  = qmult(buf_r[0], rcp_rsp_y);
               out_last_nx  = (count_r == CNT_W'(1));
            end else if (timer_r == TM_W'(TIMEOUT - 1)) begin
               state_nx     = S_EMIT;
               recip_nx     = 32'h0000_0000;
               err_nx       = 1'b1;
               rd_idx_nx    = IDX_W'(0);
               out_valid_nx = 1'b1;
               out_data_nx  = qmult(buf_r[0], 32'h0000_0000);
               out_last_nx  = (count_r == CNT_W'(1));
            end else begin
               state_nx = S_WAIT;
            end
         end

         S_EMIT: begin
            if (out_ready) begin
               if (out_last_r) begin
                  state_nx     = S_LOAD;
                  count_nx     = CNT_W'(0);
                  sum_nx       = 32'h0000_0000;
                  rd_idx_nx    = IDX_W'(0);
                  out_valid_nx = 1'b0;
                  out_data_nx  = 32'h0000_0000;
                  out_last_nx  = 1'b0;
               end else begin
                  // Preload the following element so it is presented from a register.
                  rd_idx_nx   = rd_next_s;
                  out_data_nx = qmult(buf_r[rd_next_s], recip_r);
                  out_last_nx = (CNT_W'(rd_next_s) == (count_r - CNT_W'(1)));
               end
            end else begin
               state_nx = S_EMIT;
            end
         end

         default: begin
            state_nx = S_LOAD;
         end
      endcase

      in_ready_nx = (state_nx == S_LOAD);
      busy_nx     = !((state_nx == S_LOAD) && (count_nx == CNT_W'(0)));
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_LOAD;
         count_r     <= CNT_W'(0);
         sum_r       <= 32'h0000_0000;
         recip_r     <= 32'h0000_0000;
         rd_idx_r    <= IDX_W'(0);
         timer_r     <= TM_W'(0);
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= 32'h0000_0000;
         out_last_r  <= 1'b0;
         req_valid_r <= 1'b0;
         req_x_r     <= 32'h0000_0000;
         busy_r      <= 1'b0;
         err_r       <= 1'b0;
         for (int i = 0; i < N; i++) begin
            buf_r[i] <= 32'h0000_0000;
         end
      end else begin
         state_r     <= state_nx;
         count_r     <= count_nx;
         sum_r       <= sum_nx;
         recip_r     <= recip_nx;
         rd_idx_r    <= rd_idx_nx;
         timer_r     <= timer_nx;
         in_ready_r  <= in_ready_nx;
         out_valid_r <= out_valid_nx;
         out_data_r  <= out_data_nx;
         out_last_r  <= out_last_nx;
         req_valid_r <= req_valid_nx;
         req_x_r     <= req_x_nx;
         busy_r      <= busy_nx;
         err_r       <= err_nx;
         if (buf_wr_s) begin
            buf_r[count_r[IDX_W-1:0]] <= in_data;
         end
      end
   end

   assign in_ready      = in_ready_r;
   assign out_valid     = out_valid_r;
   assign out_data      = out_data_r;
   assign out_last      = out_last_r;
   assign rcp_req_valid = req_valid_r;
   assign rcp_req_x     = req_x_r;
   assign busy          = busy_r;
   assign err           = err_r;

endmodule

// File: tb/tb_vec_normalizer.sv
// ----------------------------------------------------------------------------
// tb_vec_normalizer
// Directed bench for vec_normalizer (N=8, TIMEOUT=64). The bench plays the
// reciprocal unit itself and compares every output against hand-computed
// Q16.16 values.
// ----------------------------------------------------------------------------
module tb_vec_normalizer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        rcp_req_valid;
   logic [31:0] rcp_req_x;
   logic        rcp_rsp_valid;
   logic [31:0] rcp_rsp_y;
   logic        busy;
   logic        err;

   always #5 clk = ~clk;

   vec_normalizer #(.N(8), .TIMEOUT(64)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .rcp_req_valid (rcp_req_valid),
      .rcp_req_x     (rcp_req_x),
      .rcp_rsp_valid (rcp_rsp_valid),
      .rcp_rsp_y     (rcp_rsp_y),
      .busy          (busy),
      .err           (err)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Edge-indexed event log: each value is the index of the clock edge at
   // which the event was sampled.
   int          cyc      = 0;
   int          req_cnt  = 0;
   int          acc_cyc  = 0;
   int          req_cyc  = 0;
   int          rsp_cyc  = 0;
   int          rise_cyc = 0;
   logic [31:0] req_x    = 32'h0;
   logic        ov_d     = 1'b0;

   // Records handshakes, requests, responses and the rising edge of out_valid.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) acc_cyc <= cyc;
      if (rcp_req_valid) begin
         req_cnt <= req_cnt + 1;
         req_x   <= rcp_req_x;
         req_cyc <= cyc;
      end
      if (rcp_rsp_valid) rsp_cyc <= cyc;
      if (out_valid && !ov_d) rise_cyc <= cyc;
      ov_d <= out_valid;
   end

   logic [31:0] got_d [16];
   logic        got_l [16];
   int          got_n;

   // Presents one element at a negedge and returns at the negedge after it was accepted.
   task automatic send_elem(input logic [31:0] d, input logic l);
      int w;
      w = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) begin
         n_cmp++; n_fail++;
         $display("FAIL send_accept: in_ready stuck at %0b, required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 32'h0;
   endtask

   // Waits (bounded) until the request counter moves past base.
   task automatic wait_req(input int base);
      int w;
      w = 0;
      while (req_cnt == base && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (req_cnt == base) begin
         n_cmp++; n_fail++;
         $display("FAIL wait_req: no rcp_req_valid within 100 cycles");
      end
   endtask

   // Pulses a response so that it is sampled 'dly' edges after the request edge.
   task automatic respond(input int dly, input logic [31:0] y);
      repeat (dly - 1) @(negedge clk);
      rcp_rsp_valid = 1'b1;
      rcp_rsp_y     = y;
      @(negedge clk);
      rcp_rsp_valid = 1'b0;
      rcp_rsp_y     = 32'h0;
   endtask

   // Drains n outputs; with bp set, out_ready is low every third cycle and held data is checked.
   task automatic collect(input int n, input bit bp);
      int          budget;
      bit          held;
      logic [31:0] held_d;
      logic        held_l;
      budget = 0; held = 1'b0; held_d = 32'h0; held_l = 1'b0; got_n = 0;
      while (got_n < n && budget < 400) begin
         out_ready = bp ? ((budget % 3) != 0) : 1'b1;
         if (out_valid) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL emit_in_ready: got %0b, required 0", in_ready);
            end
            if (held) begin
               n_cmp++;
               if (out_data !== held_d || out_last !== held_l) begin
                  n_fail++;
                  $display("FAIL stall_stable: got %h/%0b, required %h/%0b", out_data, out_last, held_d, held_l);
               end
            end
            if (out_ready) begin
               got_d[got_n] = out_data;
               got_l[got_n] = out_last;
               got_n++;
               held = 1'b0;
            end else begin
               held   = 1'b1;
               held_d = out_data;
               held_l = out_last;
            end
         end
         @(negedge clk);
         budget++;
      end
      out_ready = 1'b1;
      n_cmp++;
      if (got_n != n) begin
         n_fail++;
         $display("FAIL collect_count: got %0d outputs, required %0d", got_n, n);
      end
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL after_last: out_valid=%0b busy=%0b, required 0/0", out_valid, busy);
      end
   endtask

   // Checks every output port against its reset value.
   task automatic check_reset_values(input string tag);
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_out: rdy=%0b ov=%0b od=%h ol=%0b, required 0/0/0/0", tag, in_ready, out_valid, out_data, out_last);
      end
      n_cmp++;
      if (rcp_req_valid !== 1'b0 || rcp_req_x !== 32'h0 || busy !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_ctl: rv=%0b rx=%h busy=%0b err=%0b, required 0/0/0/0", tag, rcp_req_valid, rcp_req_x, busy, err);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;
      out_ready = 1'b1; rcp_rsp_valid = 1'b0; rcp_rsp_y = 32'h0;
      #2;
      check_reset_values("reset");
      repeat (3) @(negedge clk);
      check_reset_values("reset_held");
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: in_ready=%0b busy=%0b, required 1/0", in_ready, busy);
      end
   endtask

   // Vector 1,1,2,4 -> sum 8 -> reciprocal 1/8 -> 1/8,1/8,1/4,1/2.
   task automatic test_nominal(input bit bp);
      logic [31:0] exp_d [4];
      int          base;
      exp_d[0] = 32'h0000_2000; exp_d[1] = 32'h0000_2000;
      exp_d[2] = 32'h0000_4000; exp_d[3] = 32'h0000_8000;
      base = req_cnt;
      send_elem(32'h0001_0000, 1'b0);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL nom_busy: got %0b, required 1", busy);
      end
      send_elem(32'h0001_0000, 1'b0);
      send_elem(32'h0002_0000, 1'b0);
      send_elem(32'h0004_0000, 1'b1);
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL nom_req_in_ready: got %0b, required 0", in_ready);
      end
      wait_req(base);
      n_cmp++;
      if (req_x !== 32'h0008_0000) begin
         n_fail++;
         $display("FAIL nom_req_x: got %h, required 00080000", req_x);
      end
      n_cmp++;
      if (req_cyc - acc_cyc != 1) begin
         n_fail++;
         $display("FAIL nom_req_latency: got %0d, required 1", req_cyc - acc_cyc);
      end
      respond(6, 32'h0000_2000);
      collect(4, bp);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 3)) begin
            n_fail++;
            $display("FAIL nom_out%0d: got %h/%0b, required %h/%0b", i, got_d[i], got_l[i], exp_d[i], (i == 3));
         end
      end
      n_cmp++;
      if (rise_cyc - rsp_cyc != 1) begin
         n_fail++;
         $display("FAIL nom_rsp_latency: got %0d, required 1", rise_cyc - rsp_cyc);
      end
      n_cmp++;
      if (req_cnt - base != 1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL nom_req_err: requests=%0d err=%0b, required 1/0", req_cnt - base, err);
      end
   endtask

   task automatic test_zero_sum();
      int base;
      base = req_cnt;
      send_elem(32'h0000_0000, 1'b0);
      send_elem(32'h0000_0000, 1'b1);
      collect(2, 1'b0);
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (got_d[i] !== 32'h0 || got_l[i] !== (i == 1)) begin
            n_fail++;
            $display("FAIL zero_out%0d: got %h/%0b, required 00000000/%0b", i, got_d[i], got_l[i], (i == 1));
         end
      end
      n_cmp++;
      if (rise_cyc - acc_cyc != 2) begin
         n_fail++;
         $display("FAIL zero_latency: got %0d, required 2", rise_cyc - acc_cyc);
      end
      n_cmp++;
      if (req_cnt != base || err !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_req_err: requests=%0d err=%0b, required 0/1", req_cnt - base, err);
      end
   endtask

   task automatic test_implicit_last();
      int base;
      base = req_cnt;
      for (int i = 0; i < 8; i++) send_elem(32'h0001_0000, 1'b0);
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL impl_in_ready: got %0b, required 0", in_ready);
      end
      wait_req(base);
      n_cmp++;
      if (req_x !== 32'h0008_0000 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL impl_req: x=%h err=%0b, required 00080000/0", req_x, err);
      end
      respond(6, 32'h0000_2000);
      collect(8, 1'b0);
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (got_d[i] !== 32'h0000_2000 || got_l[i] !== (i == 7)) begin
            n_fail++;
            $display("FAIL impl_out%0d: got %h/%0b, required 00002000/%0b", i, got_d[i], got_l[i], (i == 7));
         end
      end
   endtask

   task automatic test_timeout();
      int base;
      int w;
      base = req_cnt;
      out_ready = 1'b0;
      send_elem(32'h0001_0000, 1'b0);
      send_elem(32'h0001_0000, 1'b1);
      wait_req(base);
      w = 0;
      while (!out_valid && w < 200) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      // Request edge starts 64 WAIT cycles; out_valid is first sampled one edge after the exit edge.
      n_cmp++;
      if (!out_valid || rise_cyc - req_cyc != 65) begin
         n_fail++;
         $display("FAIL tmo_latency: out_valid=%0b delay=%0d, required 1/65", out_valid, rise_cyc - req_cyc);
      end
      rcp_rsp_valid = 1'b1;
      rcp_rsp_y     = 32'h7FFF_0000;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (out_data !== 32'h0 || out_valid !== 1'b1 || err !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_late_rsp: od=%h ov=%0b err=%0b, required 00000000/1/1", out_data, out_valid, err);
      end
      collect(2, 1'b0);
      rcp_rsp_valid = 1'b0;
      rcp_rsp_y     = 32'h0;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (got_d[i] !== 32'h0 || got_l[i] !== (i == 1)) begin
            n_fail++;
            $display("FAIL tmo_out%0d: got %h/%0b, required 00000000/%0b", i, got_d[i], got_l[i], (i == 1));
         end
      end
      n_cmp++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_err: got %0b, required 1", err);
      end
   endtask

   task automatic test_backpressure();
      test_nominal(1'b1);
   endtask

   task automatic test_reset_mid_wait();
      int base;
      base = req_cnt;
      send_elem(32'h0001_0000, 1'b0);
      send_elem(32'h0001_0000, 1'b1);
      wait_req(base);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_values("rst_wait");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      base = req_cnt;
      repeat (10) @(negedge clk);
      n_cmp++;
      if (req_cnt != base || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_wait_after: requests=%0d ov=%0b rdy=%0b, required 0/0/1", req_cnt - base, out_valid, in_ready);
      end
      test_nominal(1'b0);
   endtask

   initial begin
      test_reset();
      test_nominal(1'b0);
      test_zero_sum();
      test_implicit_last();
      test_timeout();
      test_backpressure();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
